// File: rtl/riscv_divider_if.sv
// AHB-Lite responder wrapping a 32-cycle restoring divider with operand, control,
// status and result registers; stalls result reads and rejects writes while busy.
module riscv_divider_if #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int W_BURST = 3
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               sl_HSEL,
  input  logic               sl_HREADY,
  input  logic [1:0]         sl_HTRANS,
  input  logic [W_BURST-1:0] sl_HBURST,
  input  logic [2:0]         sl_HSIZE,
  input  logic [W_ADDR-1:0]  sl_HADDR,
  input  logic               sl_HWRITE,
  input  logic [W_DATA-1:0]  sl_HWDATA,
  output logic               out_sl_HREADY,
  output logic [1:0]         out_sl_HRESP,
  output logic [W_DATA-1:0]  out_sl_HRDATA
);

  localparam int CW = $clog2(W_DATA);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  typedef enum logic [2:0] {
    A_OPA = 3'd0, A_OPB = 3'd1, A_CTRL = 3'd2, A_STATUS = 3'd3,
    A_QUOT = 3'd4, A_REM = 3'd5
  } addr_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [W_DATA-1:0] opa_q, opb_q, quot_q, rem_q;
  logic [W_DATA-1:0] wq_q, wr_q, wb_q;
  logic              neg_q_q, neg_r_q;
  logic              busy_q, done_q, dbz_q;
  logic              dp_valid_q, dp_write_q, err_q;
  logic [2:0]        dp_addr_q;

  logic              accept, stall_rd, err_c1, wr_fire, rd_fire, start;
  logic [W_DATA:0]   trial;
  logic [W_DATA-1:0] rd_mux;
  logic              unused_ok;

  assign unused_ok = ^{sl_HBURST, sl_HSIZE, sl_HTRANS[0], sl_HADDR[W_ADDR-1:5], sl_HADDR[1:0]};

  assign accept   = sl_HSEL & sl_HTRANS[1] & sl_HREADY;
  assign stall_rd = dp_valid_q & ~dp_write_q & busy_q &
                    ((dp_addr_q == A_QUOT) | (dp_addr_q == A_REM));
  // First error cycle; the second is carried by err_q with the data phase already retired.
  assign err_c1   = dp_valid_q & dp_write_q & busy_q;
  assign wr_fire  = dp_valid_q & dp_write_q & ~busy_q;
  assign rd_fire  = dp_valid_q & ~dp_write_q & ~stall_rd;
  assign start    = wr_fire & (dp_addr_q == A_CTRL) & sl_HWDATA[0];

  assign out_sl_HREADY = ~(stall_rd | err_c1);
  assign out_sl_HRESP  = (err_c1 | err_q) ? 2'b01 : 2'b00;
  assign out_sl_HRDATA = rd_fire ? rd_mux : '0;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  assign trial = {wr_q, wq_q[W_DATA-1]} - {1'b0, wb_q};

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (dp_addr_q)
      A_OPA:    rd_mux = opa_q;
      A_OPB:    rd_mux = opb_q;
      A_STATUS: rd_mux = {{(W_DATA-3){1'b0}}, dbz_q, done_q, busy_q};
      A_QUOT:   rd_mux = quot_q;
      A_REM:    rd_mux = rem_q;
      default:  rd_mux = '0;
    endcase
  end

  function automatic logic [W_DATA-1:0] mag(input logic [W_DATA-1:0] x, input logic sgn);
    return (sgn && x[W_DATA-1]) ? -x : x;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      err_q      <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
    end else begin
      if (err_c1) begin
        err_q      <= 1'b1;
        dp_valid_q <= 1'b0;
      end else if (out_sl_HREADY) begin
        err_q      <= 1'b0;
        dp_valid_q <= accept;
        dp_write_q <= sl_HWRITE;
        dp_addr_q  <= sl_HADDR[4:2];
      end
      if (wr_fire && dp_addr_q == A_OPA) opa_q <= sl_HWDATA;
      if (wr_fire && dp_addr_q == A_OPB) opb_q <= sl_HWDATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wq_q    <= '0;
      wr_q    <= '0;
      wb_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (opb_q == '0) begin
              // Preload the divide-by-zero result so FIN handles both paths alike.
              state_q <= S_FIN;
              wq_q    <= '1;
              wr_q    <= opa_q;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
            end else begin
              state_q <= S_CALC;
              cnt_q   <= '0;
              wq_q    <= mag(opa_q, sl_HWDATA[1]);
              wr_q    <= '0;
              wb_q    <= mag(opb_q, sl_HWDATA[1]);
              neg_q_q <= sl_HWDATA[1] & (opa_q[W_DATA-1] ^ opb_q[W_DATA-1]);
              neg_r_q <= sl_HWDATA[1] & opa_q[W_DATA-1];
            end
          end
        end
        S_CALC: begin
          if (!trial[W_DATA]) begin
            wr_q <= trial[W_DATA-1:0];
            wq_q <= {wq_q[W_DATA-2:0], 1'b1};
          end else begin
            wr_q <= {wr_q[W_DATA-2:0], wq_q[W_DATA-1]};
            wq_q <= {wq_q[W_DATA-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W_DATA-1)) state_q <= S_FIN;
        end
        S_FIN: begin
          quot_q  <= neg_q_q ? -wq_q : wq_q;
          rem_q   <= neg_r_q ? -wr_q : wr_q;
          dbz_q   <= (opb_q == '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_divider_if.sv
// Directed and randomized bus-level bench for riscv_divider_if against an
// arithmetic reference model of the divider's results.
module tb_riscv_divider_if;

  localparam logic [31:0] OPA = 32'h00, OPB = 32'h04, CTRL = 32'h08, STATUS = 32'h0C,
                          QUOT = 32'h10, REM = 32'h14, RSV = 32'h18;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sl_HSEL, sl_HREADY, sl_HWRITE;
  logic [1:0]  sl_HTRANS;
  logic [2:0]  sl_HBURST, sl_HSIZE;
  logic [31:0] sl_HADDR, sl_HWDATA;
  logic        out_sl_HREADY;
  logic [1:0]  out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;

  int checks = 0;
  int errors = 0;

  assign sl_HREADY = out_sl_HREADY;

  riscv_divider_if dut (
    .HCLK(HCLK), .HRESET(HRESET), .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY),
    .sl_HTRANS(sl_HTRANS), .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE),
    .sl_HADDR(sl_HADDR), .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
    .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP), .out_sl_HRDATA(out_sl_HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic [1:0] resp_first,
                          output logic [1:0] resp_last, output int waits);
    bit first = 1'b1;
    bit done  = 1'b0;
    sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HADDR = addr; sl_HWRITE = wr;
    @(posedge HCLK); #1;
    sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = wdata;
    waits = 0; rdata = '0; resp_first = '0; resp_last = '0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge HCLK);
      if (first) begin resp_first = out_sl_HRESP; first = 1'b0; end
      resp_last = out_sl_HRESP;
      rdata     = out_sl_HRDATA;
      if (out_sl_HREADY) done = 1'b1;
      else waits++;
      @(posedge HCLK); #1;
    end
    if (!done) begin
      checks++; errors++;
      $error("FAIL xfer_timeout: observed HREADY 0 for 200 cycles expected 1");
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd_unused;
    logic [1:0]  r0, r1;
    int          w;
    ahb_xfer(1'b1, addr, data, rd_unused, r0, r1, w);
    check("write_resp", {30'b0, r1}, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic [1:0] r0, r1;
    int         w;
    ahb_xfer(1'b0, addr, 32'h0, data, r0, r1, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0;
    end else begin
      sa = $signed(a); sb = $signed(b);
      q = 32'(sa / sb); r = 32'(sa % sb);
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, a, b, eq, er;
    logic [1:0]  r0, r1;
    int          w;
    bit          sgn;

    HRESET = 1'b1; sl_HSEL = 0; sl_HTRANS = 0; sl_HBURST = 0; sl_HSIZE = 3'b010;
    sl_HADDR = 0; sl_HWRITE = 0; sl_HWDATA = 0;
    #2;
    check("reset_hready", {31'b0, out_sl_HREADY}, 32'h1);
    check("reset_hresp", {30'b0, out_sl_HRESP}, 32'h0);
    check("reset_hrdata", out_sl_HRDATA, 32'h0);
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    rd(STATUS, d); check("reset_status", d, 32'h0);
    rd(OPA, d);    check("reset_opa", d, 32'h0);
    rd(QUOT, d);   check("reset_quot", d, 32'h0);

    // Unsigned 100/7 with exact 33-cycle latency.
    wr(OPA, 100); wr(OPB, 7); wr(CTRL, 32'h1);
    idle(31); rd(STATUS, d); check("busy_at_e32", d, 32'h1);
    rd(STATUS, d); check("unsigned_status", d, 32'h2);
    rd(QUOT, d);   check("unsigned_quot", d, 32'd14);
    rd(REM, d);    check("unsigned_rem", d, 32'd2);
    rd(OPB, d);    check("opb_readback", d, 32'd7);
    wr(CTRL, 32'h1);
    idle(32); rd(STATUS, d); check("done_at_e33", d, 32'h2);

    // Signed cases.
    wr(OPA, 32'hFFFF_FFF9); wr(OPB, 2); wr(CTRL, 32'h3);
    idle(40);
    rd(QUOT, d); check("signed_quot", d, 32'hFFFF_FFFD);
    rd(REM, d);  check("signed_rem", d, 32'hFFFF_FFFF);
    wr(OPA, 32'h8000_0000); wr(OPB, 32'hFFFF_FFFF); wr(CTRL, 32'h3);
    idle(40);
    rd(QUOT, d); check("ovf_quot", d, 32'h8000_0000);
    rd(REM, d);  check("ovf_rem", d, 32'h0);

    // Divide by zero.
    wr(OPA, 32'h1234); wr(OPB, 0); wr(CTRL, 32'h1);
    rd(STATUS, d); check("dbz_status", d, 32'h6);
    rd(QUOT, d);   check("dbz_quot", d, 32'hFFFF_FFFF);
    rd(REM, d);    check("dbz_rem", d, 32'h1234);

    // Read stall on QUOT right after start.
    wr(OPA, 100); wr(OPB, 7); wr(CTRL, 32'h1);
    ahb_xfer(1'b0, QUOT, 32'h0, d, r0, r1, w);
    check("stall_waits", 32'(w), 32'd32);
    check("stall_rdata", d, 32'd14);
    check("stall_resp", {30'b0, r1}, 32'h0);

    // Write while busy: two-cycle ERROR, no register change.
    wr(CTRL, 32'h1);
    ahb_xfer(1'b1, OPA, 32'd5, d, r0, r1, w);
    check("err_waits", 32'(w), 32'd1);
    check("err_resp1", {30'b0, r0}, 32'h1);
    check("err_resp2", {30'b0, r1}, 32'h1);
    idle(40);
    rd(OPA, d);  check("err_opa_kept", d, 32'd100);
    rd(QUOT, d); check("err_quot", d, 32'd14);
    rd(CTRL, d); check("ctrl_reads_zero", d, 32'h0);
    wr(STATUS, 32'hFF); rd(STATUS, d); check("status_ro", d, 32'h2);
    wr(RSV, 32'hABCD);  rd(RSV, d);    check("reserved_zero", d, 32'h0);

    // Reset mid-division while a QUOT read is stalled.
    wr(CTRL, 32'h1);
    sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HADDR = QUOT; sl_HWRITE = 1'b0;
    @(posedge HCLK); #1;
    sl_HSEL = 1'b0; sl_HTRANS = 2'b00;
    repeat (8) @(posedge HCLK);
    #1 check("pre_reset_stall", {31'b0, out_sl_HREADY}, 32'h0);
    @(posedge HCLK); #1 HRESET = 1'b1;
    #1;
    check("midrst_hready", {31'b0, out_sl_HREADY}, 32'h1);
    check("midrst_hrdata", out_sl_HRDATA, 32'h0);
    check("midrst_hresp", {30'b0, out_sl_HRESP}, 32'h0);
    @(posedge HCLK); #1 HRESET = 1'b0;
    rd(STATUS, d); check("midrst_status", d, 32'h0);
    rd(QUOT, d);   check("midrst_quot", d, 32'h0);
    rd(OPA, d);    check("midrst_opa", d, 32'h0);
    wr(OPA, 9); wr(OPB, 3); wr(CTRL, 32'h1);
    idle(40);
    rd(QUOT, d); check("post_rst_quot", d, 32'd3);
    rd(REM, d);  check("post_rst_rem", d, 32'd0);

    // Randomized operands against the reference model.
    for (int t = 0; t < 20; t++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (t == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      sgn = 1'($urandom_range(0, 1));
      ref_div(a, b, sgn, eq, er);
      wr(OPA, a); wr(OPB, b); wr(CTRL, {30'b0, sgn, 1'b1});
      d = 32'h1;
      for (int p = 0; p < 60 && d[0]; p++) rd(STATUS, d);
      check("rand_status", d, (b == 0) ? 32'h6 : 32'h2);
      rd(QUOT, d); check("rand_quot", d, eq);
      rd(REM, d);  check("rand_rem", d, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
